// File: rtl/match_judge.sv
// Pair-judging rule engine closing the loop around card_array selections.
// Optional miss counter output enabled by MATCH_JUDGE_MISS_COUNT_EN.
module match_judge #(
    parameter int NUM_CARDS   = 36,
    parameter int FACE_W      = 4,
    parameter int HOLD_CYCLES = 25000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_CARDS-1:0]        sel_bus,
    input  logic [NUM_CARDS-1:0]        hidden_bus,
    input  logic [NUM_CARDS*FACE_W-1:0] face_bus,
    output logic                        ms,
    output logic                        mf,
    output logic                        busy,
    output logic [5:0]                  pairs,
`ifdef MATCH_JUDGE_MISS_COUNT_EN
    output logic [7:0]                  misses,
`endif
    output logic                        win
);

    localparam int IDX_W = (NUM_CARDS > 2) ? $clog2(NUM_CARDS) : 1;
    localparam int CNT_W = $clog2(NUM_CARDS + 1);
    localparam int HC_W  = $clog2(HOLD_CYCLES) + 1;

    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(HOLD_CYCLES - 1);
    localparam logic [5:0]       MAX_PAIRS = 6'(NUM_CARDS / 2);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        VERDICT,
        WAIT
    } state_t;

    state_t state_q, state_d;

    logic [NUM_CARDS-1:0] eff;
    logic [NUM_CARDS-1:0] eff_q;
    logic [CNT_W-1:0]     cnt_d, cnt_q;
    logic [IDX_W-1:0]     lo, hi;
    logic [IDX_W-1:0]     idx_a_q, idx_b_q;
    logic [HC_W-1:0]      hold_q;
    logic                 result_q;
    logic                 hold_done;
    logic [FACE_W-1:0]    face_a, face_b;
    logic                 ms_d, mf_d, busy_d;

    assign eff       = sel_bus & ~hidden_bus;
    assign hold_done = (hold_q == HOLD_LAST);
    assign face_a    = face_bus[idx_a_q*FACE_W +: FACE_W];
    assign face_b    = face_bus[idx_b_q*FACE_W +: FACE_W];

    always_comb begin
        cnt_d = '0;
        for (int i = 0; i < NUM_CARDS; i++)
            cnt_d = cnt_d + CNT_W'(eff[i]);
    end

    // Pair endpoints come from the registered selection so they line up with cnt_q.
    always_comb begin
        lo = '0;
        hi = '0;
        for (int i = NUM_CARDS - 1; i >= 0; i--)
            if (eff_q[i]) lo = IDX_W'(i);
        for (int i = 0; i < NUM_CARDS; i++)
            if (eff_q[i]) hi = IDX_W'(i);
    end

    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!win && cnt_q == CNT_TWO)     state_d = HOLD;
                else if (!win && cnt_q > CNT_TWO) state_d = VERDICT;
            end
            HOLD:    if (hold_done) state_d = VERDICT;
            VERDICT: state_d = WAIT;
            WAIT:    if (cnt_q == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        ms_d   = (state_q == VERDICT) &&  result_q;
        mf_d   = (state_q == VERDICT) && !result_q;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            eff_q    <= '0;
            cnt_q    <= '0;
            idx_a_q  <= '0;
            idx_b_q  <= '0;
            hold_q   <= '0;
            result_q <= 1'b0;
            ms       <= 1'b0;
            mf       <= 1'b0;
            busy     <= 1'b0;
            pairs    <= '0;
            win      <= 1'b0;
        end else begin
            eff_q <= eff;
            cnt_q <= cnt_d;
            ms    <= ms_d;
            mf    <= mf_d;
            busy  <= busy_d;
            win   <= win | (pairs == MAX_PAIRS) | (&hidden_bus);
            hold_q <= (state_q == HOLD) ? hold_q + 1'b1 : '0;
            if (state_q == IDLE && state_d == HOLD) begin
                idx_a_q <= lo;
                idx_b_q <= hi;
            end
            // Overflow selections are judged as a miss without a hold interval.
            if (state_q == IDLE && state_d == VERDICT)
                result_q <= 1'b0;
            else if (state_q == HOLD && hold_done)
                result_q <= (face_a == face_b);
            if (ms_d && pairs != MAX_PAIRS)
                pairs <= pairs + 1'b1;
        end
    end

`ifdef MATCH_JUDGE_MISS_COUNT_EN
    always_ff @(posedge clk) begin
        if (!rst)
            misses <= '0;
        else if (mf_d && misses != 8'hff)
            misses <= misses + 1'b1;
    end
`endif

endmodule

// File: tb/tb_match_judge.sv
// Bench for match_judge: directed rule checks plus randomized play to a win.
// Reference model works per turn from the game rules, not per cycle.
module tb_match_judge;

    localparam int N    = 10;
    localparam int FW   = 4;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  sel_bus;
    logic [N-1:0]  hidden_bus;
    logic [N*FW-1:0] face_bus;
    logic          ms, mf, busy, win;
    logic [5:0]    pairs;
`ifdef MATCH_JUDGE_MISS_COUNT_EN
    logic [7:0]    misses;
`endif

    logic [FW-1:0] faces [N];

    int n_assert = 0;
    int n_fail   = 0;

    int      m_pairs;
    int      m_misses;
    bit      m_win;
    logic [N-1:0] m_hid;

    match_judge #(
        .NUM_CARDS  (N),
        .FACE_W     (FW),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sel_bus   (sel_bus),
        .hidden_bus(hidden_bus),
        .face_bus  (face_bus),
        .ms        (ms),
        .mf        (mf),
        .busy      (busy),
        .pairs     (pairs),
`ifdef MATCH_JUDGE_MISS_COUNT_EN
        .misses    (misses),
`endif
        .win       (win)
    );

    always #5 clk = ~clk;

    always_comb begin
        face_bus = '0;
        for (int i = 0; i < N; i++)
            face_bus[i*FW +: FW] = faces[i];
    end

    task automatic check(input string tag, input string what,
                         input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
        end
    endtask

    // One selection turn: drive sel/hid, watch a bounded window, compare with the rules.
    task automatic run_turn(input logic [N-1:0] sel, input logic [N-1:0] hid,
                            input int twiddle, input string tag);
        logic [N-1:0]  eff;
        logic [FW-1:0] f [N];
        int cnt, lat, a, b, first, pulses, np, nm;
        bit exp_pulse, exp_ms, saw_ms, nwin;
        eff = sel & ~hid;
        cnt = $countones(eff);
        a = -1;
        b = -1;
        for (int i = 0; i < N; i++) begin
            f[i] = faces[i];
            if (eff[i] && a < 0) a = i;
            if (eff[i]) b = i;
        end
        if (twiddle >= 0) f[twiddle] = f[twiddle] ^ 4'h1;
        exp_pulse = !m_win && cnt >= 2;
        exp_ms    = exp_pulse && cnt == 2 && f[a] == f[b];
        lat       = (cnt == 2) ? HOLD + 3 : 3;
        np = m_pairs;
        nm = m_misses;
        if (exp_pulse && exp_ms && np < N / 2) np++;
        if (exp_pulse && !exp_ms && nm < 255) nm++;
        nwin = m_win || (np == N / 2) || (&hid);
        @(negedge clk);
        sel_bus    = sel;
        hidden_bus = hid;
        first  = 0;
        pulses = 0;
        saw_ms = 1'b0;
        for (int k = 1; k <= lat + 20; k++) begin
            @(negedge clk);
            if (k == 3 && twiddle >= 0) faces[twiddle] = faces[twiddle] ^ 4'h1;
            if (first != 0 && k == first + 1)
                check(tag, "win_after_pulse", 32'(win), 32'(nwin));
            if (ms || mf) begin
                pulses++;
                if (first == 0) begin
                    first  = k;
                    saw_ms = ms;
                    check(tag, "not_both", 32'({ms, mf} == 2'b11), 32'd0);
                    check(tag, "pairs_at_pulse", 32'(pairs), 32'(np));
                    check(tag, "win_at_pulse", 32'(win), 32'(m_win || (&hid)));
                end
            end
        end
        check(tag, "pulses", 32'(pulses), 32'(exp_pulse));
        if (exp_pulse) begin
            check(tag, "latency", 32'(first), 32'(lat));
            check(tag, "is_ms", 32'(saw_ms), 32'(exp_ms));
        end
        check(tag, "busy_held", 32'(busy), 32'(exp_pulse));
        m_pairs  = np;
        m_misses = nm;
        m_win    = nwin;
        check(tag, "pairs", 32'(pairs), 32'(m_pairs));
        check(tag, "win", 32'(win), 32'(m_win));
`ifdef MATCH_JUDGE_MISS_COUNT_EN
        check(tag, "misses", 32'(misses), 32'(m_misses));
`endif
        sel_bus = '0;
        repeat (3) @(negedge clk);
        check(tag, "busy_released", 32'(busy), 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst        = 1'b0;
        sel_bus    = '0;
        hidden_bus = '0;
        repeat (3) @(negedge clk);
        check("reset", "ms", 32'(ms), 32'd0);
        check("reset", "mf", 32'(mf), 32'd0);
        check("reset", "busy", 32'(busy), 32'd0);
        check("reset", "pairs", 32'(pairs), 32'd0);
        check("reset", "win", 32'(win), 32'd0);
        rst      = 1'b1;
        m_pairs  = 0;
        m_misses = 0;
        m_win    = 1'b0;
        m_hid    = '0;
    endtask

    initial begin
        int q [$];
        int i, j, p, t, pulses;
        logic [N-1:0] s;
        logic [FW-1:0] tmp;
        rst        = 1'b0;
        sel_bus    = '0;
        hidden_bus = '0;
        faces = '{4'd3, 4'd2, 4'd7, 4'd9, 4'd9, 4'd3, 4'd10, 4'd11, 4'd11, 4'd13};
        do_reset();

        run_turn(10'b00_0010_0001, m_hid, -1, "match_0_5");
        m_hid = m_hid | 10'b00_0010_0001;
        run_turn(10'b00_0000_0110, m_hid, -1, "mismatch_1_2");
        run_turn(10'b10_0001_1000, m_hid | 10'b10_0000_0000, -1, "masked_3_4");
        m_hid = m_hid | 10'b00_0001_1000;
        run_turn(10'b00_0100_0110, m_hid, -1, "overflow");
        run_turn(10'b01_1000_0000, m_hid, 8, "late_face");

        // Reset lands while the hold counter sits at 2.
        @(negedge clk);
        sel_bus    = 10'b00_0100_0010;
        hidden_bus = m_hid;
        repeat (4) @(negedge clk);
        rst     = 1'b0;
        sel_bus = '0;
        @(negedge clk);
        rst = 1'b1;
        check("reset_hold", "busy", 32'(busy), 32'd0);
        check("reset_hold", "pairs", 32'(pairs), 32'd0);
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            if (ms || mf) pulses++;
            @(negedge clk);
        end
        check("reset_hold", "pulses", 32'(pulses), 32'd0);
        m_pairs  = 0;
        m_misses = 0;
        m_win    = 1'b0;
        m_hid    = '0;
        hidden_bus = '0;

        for (int k = 0; k < N; k++) faces[k] = FW'(k / 2 + 1);
        for (int k = N - 1; k > 0; k--) begin
            j = $urandom_range(0, k);
            tmp = faces[k];
            faces[k] = faces[j];
            faces[j] = tmp;
        end

        t = 0;
        while (!m_win && t < 40) begin
            q.delete();
            for (int k = 0; k < N; k++)
                if (!m_hid[k]) q.push_back(k);
            s = '0;
            p = $urandom_range(0, q.size() - 1);
            i = q[p];
            q.delete(p);
            if (t % 5 == 4 && q.size() >= 2) begin
                s[i] = 1'b1;
                p = $urandom_range(0, q.size() - 1);
                s[q[p]] = 1'b1;
                q.delete(p);
                s[q[$urandom_range(0, q.size() - 1)]] = 1'b1;
            end else begin
                j = q[$urandom_range(0, q.size() - 1)];
                if (t % 2 == 1)
                    foreach (q[k]) if (faces[q[k]] == faces[i]) j = q[k];
                s[i] = 1'b1;
                s[j] = 1'b1;
            end
            run_turn(s, m_hid, -1, $sformatf("rand%0d", t));
            if ($countones(s) == 2 && faces[i] == faces[j]) m_hid = m_hid | s;
            t++;
        end
        check("random", "win_reached", 32'(win), 32'd1);

        run_turn(10'b00_0000_0011, '0, -1, "post_win");

        do_reset();
        @(negedge clk);
        hidden_bus = '1;
        @(negedge clk);
        check("all_hidden", "win", 32'(win), 32'd1);
        check("all_hidden", "pairs", 32'(pairs), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
